// File: rtl/aes_frame_assembler.sv
// Assembles a header byte plus 16 UART payload bytes into a 128-bit AES key or
// plaintext block, then hands it to the key expander or the cipher.
module aes_frame_assembler #(
    parameter logic [7:0] HDR_KEY        = 8'h4B,
    parameter logic [7:0] HDR_DATA       = 8'h50,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic [127:0] key,
    output logic         key_start,
    input  logic         key_done,
    output logic         key_loaded,
    output logic [127:0] pt_data,
    output logic         pt_valid,
    input  logic         pt_ready,
    output logic         busy,
    output logic         frame_err,
    output logic         overrun
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_HDR, S_BYTES, S_KEY_WAIT, S_PT_HOLD} state_e;

    state_e        state_q, state_d;
    logic [127:0]  shift_q, shift_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          is_key_q, is_key_d;
    logic [127:0]  key_q, key_d;
    logic [127:0]  pt_data_q, pt_data_d;
    logic          pt_valid_q, pt_valid_d;
    logic          key_start_q, key_start_d;
    logic          key_loaded_q, key_loaded_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [127:0]  assembled;

    assign assembled = {shift_q[119:0], rx_data};

    always_comb begin
        // NOTE: every signal gets its hold/idle value first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        is_key_d     = is_key_q;
        key_d        = key_q;
        pt_data_d    = pt_data_q;
        pt_valid_d   = pt_valid_q;
        key_loaded_d = key_loaded_q;
        key_start_d  = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        case (state_q)
            S_HDR: begin
                if (rx_valid) begin
                    if (rx_data == HDR_KEY || rx_data == HDR_DATA) begin
                        is_key_d = (rx_data == HDR_KEY);
                        cnt_d    = '0;
                        tmo_d    = '0;
                        state_d  = S_BYTES;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            S_BYTES: begin
                // A byte arriving on the threshold cycle wins over the timeout.
                if (rx_valid) begin
                    shift_d = assembled;
                    cnt_d   = cnt_q + 4'd1;
                    tmo_d   = '0;
                    if (cnt_q == 4'd15) begin
                        if (is_key_q) begin
                            key_d       = assembled;
                            key_start_d = 1'b1;
                            state_d     = S_KEY_WAIT;
                        end else begin
                            pt_data_d  = assembled;
                            pt_valid_d = 1'b1;
                            state_d    = S_PT_HOLD;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = S_HDR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_KEY_WAIT: begin
                overrun_d = rx_valid;
                if (key_done) begin
                    key_loaded_d = 1'b1;
                    state_d      = S_HDR;
                end
            end
            S_PT_HOLD: begin
                overrun_d = rx_valid;
                if (pt_valid_q && pt_ready) begin
                    pt_valid_d = 1'b0;
                    state_d    = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_HDR;
            shift_q      <= '0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            is_key_q     <= 1'b0;
            key_q        <= '0;
            pt_data_q    <= '0;
            pt_valid_q   <= 1'b0;
            key_start_q  <= 1'b0;
            key_loaded_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            is_key_q     <= is_key_d;
            key_q        <= key_d;
            pt_data_q    <= pt_data_d;
            pt_valid_q   <= pt_valid_d;
            key_start_q  <= key_start_d;
            key_loaded_q <= key_loaded_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign key        = key_q;
    assign key_start  = key_start_q;
    assign key_loaded = key_loaded_q;
    assign pt_data    = pt_data_q;
    assign pt_valid   = pt_valid_q;
    assign busy       = (state_q == S_KEY_WAIT) || (state_q == S_PT_HOLD);
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_aes_frame_assembler.sv
// Directed bench for aes_frame_assembler: key/plaintext frames, bad header,
// timeout, overrun and mid-frame reset.
module tb_aes_frame_assembler;

    localparam int TMO = 8;
    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY3 = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT3  = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         key_done = 1'b0;
    logic         pt_ready = 1'b0;
    logic [127:0] key, pt_data;
    logic         key_start, key_loaded, pt_valid, busy, frame_err, overrun;

    int total = 0;
    int bad = 0;

    aes_frame_assembler #(
        .HDR_KEY(8'h4B), .HDR_DATA(8'h50), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .key(key), .key_start(key_start), .key_done(key_done), .key_loaded(key_loaded),
        .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready), .busy(busy),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [127:0] payload);
        send_byte(hdr);
        for (int i = 0; i < 16; i++) send_byte(payload[127-8*i -: 8]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++; if (key !== 128'h0) begin bad++; $display("FAIL reset_key: got %h expected 0", key); end
        total++; if (pt_data !== 128'h0) begin bad++; $display("FAIL reset_pt_data: got %h expected 0", pt_data); end
        total++; if ({key_start, key_loaded, pt_valid, busy, frame_err, overrun} !== 6'b0) begin
            bad++; $display("FAIL reset_flags: got %b expected 000000",
                            {key_start, key_loaded, pt_valid, busy, frame_err, overrun});
        end
        #9 rst_n = 1'b1;
    endtask

    task automatic test_key_frame();
        send_frame(8'h4B, KEY1);
        total++; if (key !== KEY1) begin bad++; $display("FAIL key_value: got %h expected %h", key, KEY1); end
        total++; if ({key_start, busy, key_loaded} !== 3'b110) begin
            bad++; $display("FAIL key_start_busy: got %b expected 110", {key_start, busy, key_loaded});
        end
        tick();
        total++; if ({key_start, busy} !== 2'b01) begin
            bad++; $display("FAIL key_start_one_cycle: got %b expected 01", {key_start, busy});
        end
        key_done = 1'b1;
        tick();
        key_done = 1'b0;
        total++; if ({busy, key_loaded, key_start} !== 3'b010) begin
            bad++; $display("FAIL key_done_exit: got %b expected 010", {busy, key_loaded, key_start});
        end
        total++; if (key !== KEY1) begin bad++; $display("FAIL key_hold_after_done: got %h expected %h", key, KEY1); end
    endtask

    task automatic test_pt_hold();
        pt_ready = 1'b0;
        send_frame(8'h50, PT1);
        total++; if ({pt_valid, busy} !== 2'b11 || pt_data !== PT1) begin
            bad++; $display("FAIL pt_first: got v/b=%b data=%h expected 11 %h", {pt_valid, busy}, pt_data, PT1);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (pt_valid !== 1'b1 || pt_data !== PT1) begin
                bad++; $display("FAIL pt_held_%0d: got v=%b data=%h expected 1 %h", i, pt_valid, pt_data, PT1);
            end
        end
        send_byte(8'h4B);
        total++; if ({overrun, pt_valid} !== 2'b11) begin
            bad++; $display("FAIL pt_hold_overrun: got %b expected 11", {overrun, pt_valid});
        end
        pt_ready = 1'b1;
        send_byte(8'h41);
        pt_ready = 1'b0;
        total++; if ({pt_valid, busy, overrun} !== 3'b001 || pt_data !== PT1) begin
            bad++; $display("FAIL pt_handshake: got v/b/o=%b data=%h expected 001 %h",
                            {pt_valid, busy, overrun}, pt_data, PT1);
        end
        tick();
        total++; if ({frame_err, overrun} !== 2'b00) begin
            bad++; $display("FAIL pt_exit_byte_dropped: got %b expected 00", {frame_err, overrun});
        end
    endtask

    task automatic test_bad_header();
        send_byte(8'h41);
        total++; if ({frame_err, busy} !== 2'b10) begin
            bad++; $display("FAIL bad_hdr_err: got %b expected 10", {frame_err, busy});
        end
        tick();
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL bad_hdr_pulse: got %b expected 0", frame_err); end
        send_frame(8'h4B, KEY2);
        total++; if (key !== KEY2 || key_start !== 1'b1) begin
            bad++; $display("FAIL bad_hdr_recover: got %h/%b expected %h/1", key, key_start, KEY2);
        end
        key_done = 1'b1;
        tick();
        key_done = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bad_hdr_exit: got busy=%b expected 0", busy); end
    endtask

    task automatic test_timeout();
        send_byte(8'h50);
        for (int i = 0; i < 5; i++) send_byte(8'h90 + 8'(i));
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            total++; if (frame_err !== 1'b0) begin
                bad++; $display("FAIL timeout_early_%0d: got %b expected 0", i, frame_err);
            end
        end
        tick();
        total++; if ({frame_err, pt_valid, busy} !== 3'b100 || pt_data !== PT1) begin
            bad++; $display("FAIL timeout_abort: got e/v/b=%b data=%h expected 100 %h",
                            {frame_err, pt_valid, busy}, pt_data, PT1);
        end
        pt_ready = 1'b1;
        send_frame(8'h50, PT2);
        total++; if (pt_data !== PT2 || pt_valid !== 1'b1) begin
            bad++; $display("FAIL timeout_new_frame: got %h/%b expected %h/1", pt_data, pt_valid, PT2);
        end
        tick();
        pt_ready = 1'b0;
        total++; if ({pt_valid, busy} !== 2'b00) begin
            bad++; $display("FAIL early_ready_handshake: got %b expected 00", {pt_valid, busy});
        end
    endtask

    task automatic test_threshold_byte();
        logic [127:0] v;
        v = PT3;
        send_byte(8'h50);
        for (int i = 0; i < 16; i++) begin
            if (i == 3) repeat (TMO - 1) tick();
            send_byte(v[127-8*i -: 8]);
            if (i == 3) begin
                total++; if (frame_err !== 1'b0) begin
                    bad++; $display("FAIL threshold_byte_err: got %b expected 0", frame_err);
                end
            end
        end
        total++; if (pt_data !== PT3 || pt_valid !== 1'b1) begin
            bad++; $display("FAIL threshold_frame: got %h/%b expected %h/1", pt_data, pt_valid, PT3);
        end
        pt_ready = 1'b1;
        tick();
        pt_ready = 1'b0;
        total++; if (pt_valid !== 1'b0) begin bad++; $display("FAIL threshold_release: got %b expected 0", pt_valid); end
    endtask

    task automatic test_overrun();
        send_frame(8'h4B, KEY3);
        total++; if (key !== KEY3) begin bad++; $display("FAIL ovr_key: got %h expected %h", key, KEY3); end
        send_byte(8'h4B);
        total++; if ({overrun, busy} !== 2'b11) begin
            bad++; $display("FAIL ovr_first: got %b expected 11", {overrun, busy});
        end
        tick();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_pulse: got %b expected 0", overrun); end
        send_byte(8'h50);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_second: got %b expected 1", overrun); end
        key_done = 1'b1;
        send_byte(8'h41);
        key_done = 1'b0;
        total++; if ({overrun, busy, key_loaded, frame_err} !== 4'b1010) begin
            bad++; $display("FAIL ovr_with_done: got %b expected 1010", {overrun, busy, key_loaded, frame_err});
        end
        tick();
        total++; if ({overrun, frame_err, busy} !== 3'b000 || key !== KEY3) begin
            bad++; $display("FAIL ovr_exit: got o/e/b=%b key=%h expected 000 %h", {overrun, frame_err, busy}, key, KEY3);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [127:0] v;
        v = KEY1;
        send_byte(8'h4B);
        for (int i = 0; i < 10; i++) send_byte(v[127-8*i -: 8]);
        rst_n = 1'b0;
        #2;
        total++; if (key !== 128'h0 || pt_data !== 128'h0) begin
            bad++; $display("FAIL midrst_data: got %h/%h expected 0/0", key, pt_data);
        end
        total++; if ({key_start, key_loaded, pt_valid, busy, frame_err, overrun} !== 6'b0) begin
            bad++; $display("FAIL midrst_flags: got %b expected 000000",
                            {key_start, key_loaded, pt_valid, busy, frame_err, overrun});
        end
        #2 rst_n = 1'b1;
        send_frame(8'h4B, KEY1);
        total++; if (key !== KEY1 || {key_start, busy} !== 2'b11) begin
            bad++; $display("FAIL midrst_refill: got %h/%b expected %h/11", key, {key_start, busy}, KEY1);
        end
        tick();
        key_done = 1'b1;
        tick();
        key_done = 1'b0;
        total++; if ({key_loaded, busy} !== 2'b10) begin
            bad++; $display("FAIL midrst_loaded: got %b expected 10", {key_loaded, busy});
        end
    endtask

    initial begin
        test_reset();
        test_key_frame();
        test_pt_hold();
        test_bad_header();
        test_timeout();
        test_threshold_byte();
        test_overrun();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
